gain_voies_sched: RTL

GAIN_VOIES_SCHED -- requirements
Module: gain_voies_sched

---
 rtl/gain_voies_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gain_voies_sched.sv
// gain_voies_sched: round-robin multi-channel gain scaler sharing one multiplier (2-stage pipeline).
// Build option GAIN_VOIES_SAT_EN: saturate out-of-range results and pulse ovf; otherwise wrap.
module gain_voies_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 16,
  parameter int unsigned GW  = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   enable,
  input  logic [NCH-1:0]         s_valid,
  output logic [NCH-1:0]         s_ready,
  input  logic [NCH*DW-1:0]      s_data,
  input  logic [NCH*GW-1:0]      gain,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          m_data,
  output logic [$clog2(NCH)-1:0] m_chan,
  output logic                   busy,
  output logic                   ovf
);
  localparam int unsigned CW   = $clog2(NCH);
  localparam int unsigned PW   = DW + GW;
  localparam int unsigned FRAC = 14;

  logic [CW-1:0]        ptr_q, ptr_d;
  logic                 s1_vld_q, s1_vld_d;
  logic signed [DW-1:0] s1_data_q, s1_data_d;
  logic signed [GW-1:0] s1_gain_q, s1_gain_d;
  logic [CW-1:0]        s1_chan_q, s1_chan_d;
  logic                 m_valid_q, m_valid_d;
  logic [DW-1:0]        m_data_q, m_data_d;
  logic [CW-1:0]        m_chan_q, m_chan_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  logic                 s2_load_c, s1_load_c, found_c;
  logic [CW-1:0]        idx_c, gnt_idx_c;
  logic [NCH-1:0]       grant_c;
  logic [DW-1:0]        sel_data_c;
  logic [GW-1:0]        sel_gain_c;
  logic signed [PW-1:0] prod_c, shifted_c;
  logic [DW-1:0]        res_c;
  logic                 clip_c;

  // Load enables and round-robin search starting after the last accepted channel
  always_comb begin
    s2_load_c = !m_valid_q || m_ready;
    s1_load_c = !s1_vld_q || s2_load_c;
    found_c   = 1'b0;
    idx_c     = '0;
    gnt_idx_c = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx_c = CW'((32'(ptr_q) + i) % NCH);
      if (!found_c && s_valid[idx_c]) begin
        found_c   = 1'b1;
        gnt_idx_c = idx_c;
      end
    end
    grant_c = '0;
    if (found_c && enable && s1_load_c && ARESETN) grant_c[gnt_idx_c] = 1'b1;
    sel_data_c = '0;
    sel_gain_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CW'(i) == gnt_idx_c) begin
        sel_data_c = s_data[i*DW +: DW];
        sel_gain_c = gain[i*GW +: GW];
      end
    end
  end

  // Shared multiplier: full-precision Q2.14 product, floor shift, then clip or wrap
  always_comb begin
    prod_c    = PW'(s1_data_q) * PW'(s1_gain_q);
    shifted_c = prod_c >>> FRAC;
`ifdef GAIN_VOIES_SAT_EN
    clip_c = !((&shifted_c[PW-1:DW-1]) || !(|shifted_c[PW-1:DW-1]));
    if (clip_c) res_c = shifted_c[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else        res_c = shifted_c[DW-1:0];
`else
    clip_c = 1'b0;
    res_c  = shifted_c[DW-1:0];
`endif
  end

`ifndef GAIN_VOIES_SAT_EN
  logic unused_c;
  assign unused_c = ^shifted_c[PW-1:DW];
`endif

  always_comb begin
    ptr_d     = ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_gain_d = s1_gain_q;
    s1_chan_d = s1_chan_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    ovf_d     = 1'b0;
    if (s1_load_c) begin
      s1_vld_d = |grant_c;
      if (|grant_c) begin
        s1_data_d = sel_data_c;
        s1_gain_d = sel_gain_c;
        s1_chan_d = gnt_idx_c;
        ptr_d     = gnt_idx_c;
      end
    end
    if (s2_load_c) begin
      m_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        m_data_d = res_c;
        m_chan_d = s1_chan_q;
        ovf_d    = clip_c;
      end
    end
    busy_d = s1_vld_d || m_valid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr_q     <= CW'(NCH - 1);
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_gain_q <= '0;
      s1_chan_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_gain_q <= s1_gain_d;
      s1_chan_q <= s1_chan_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready = grant_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
endmodule
